// File: rtl/fifo_write_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : fifo_write_arbiter_pkg                                     |
// | Shared state encoding, grant encodings and helpers for the FIFO      |
// | write-port arbiter.                                                  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package fifo_write_arbiter_pkg;

   // Arbiter control states: waiting for a packet start, or owned by a source
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   // One-hot grant encodings presented on the grant output
   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_0    = 2'b01;
   localparam logic [1:0] GNT_1    = 2'b10;

   // Map the registered owner index onto its one-hot grant code
   function automatic logic [1:0] owner_to_grant(input logic owner);
      return owner ? GNT_1 : GNT_0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_write_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : fifo_write_arbiter_if                                    |
// | Bundles both packet-source handshakes, the FIFO write side and the   |
// | arbiter status outputs.                                              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface fifo_write_arbiter_if #(
   parameter int c_DATAWIDTH = 8
);
   // Source 0 handshake
   logic                   req0_valid;
   logic [c_DATAWIDTH-1:0] req0_data;
   logic                   req0_last;
   logic                   req0_ready;

   // Source 1 handshake
   logic                   req1_valid;
   logic [c_DATAWIDTH-1:0] req1_data;
   logic                   req1_last;
   logic                   req1_ready;

   // FIFO write port and flow-control flags
   logic                   fifo_writeen;
   logic [c_DATAWIDTH-1:0] fifo_data;
   logic                   fifo_full;
   logic                   fifo_nearfull;

   // Arbiter status
   logic [1:0]             grant;
   logic                   abort;

   // Sources plus FIFO environment, seen from outside the arbiter
   modport master (
      output req0_valid, req0_data, req0_last,
      input  req0_ready,
      output req1_valid, req1_data, req1_last,
      input  req1_ready,
      input  fifo_writeen, fifo_data,
      output fifo_full, fifo_nearfull,
      input  grant, abort
   );

   // The arbiter itself
   modport slave (
      input  req0_valid, req0_data, req0_last,
      output req0_ready,
      input  req1_valid, req1_data, req1_last,
      output req1_ready,
      output fifo_writeen, fifo_data,
      input  fifo_full, fifo_nearfull,
      output grant, abort
   );
endinterface
`default_nettype wire

// File: rtl/fifo_write_arbiter_idle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fifo_write_arbiter_idle_timer                              |
// | Counts idle cycles of the current owner; expired once the counter    |
// | reaches all-ones. Clear has priority over enable.                    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module fifo_write_arbiter_idle_timer #(
   parameter int c_TIMEOUTW = 8
) (
   input  wire logic i_clock,
   input  wire logic i_reset,
   input  wire logic i_clear,
   input  wire logic i_enable,
   output logic      o_expired
);

   localparam logic [c_TIMEOUTW-1:0] c_ONE = {{(c_TIMEOUTW-1){1'b0}}, 1'b1};

   logic [c_TIMEOUTW-1:0] r_count;

   // Idle counter: cleared on owner activity, saturates at all-ones
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_expired) begin
         r_count <= r_count + c_ONE;
      end
   end

   assign o_expired = &r_count;

endmodule
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fifo_write_arbiter                                         |
// | Round-robin, packet-granular sharing of one FIFO write port between  |
// | two sources, with nearfull start gating and idle-timeout reclaim.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module fifo_write_arbiter
   import fifo_write_arbiter_pkg::*;
#(
   parameter int c_DATAWIDTH = 8,
   parameter int c_TIMEOUTW  = 8
) (
   input  wire logic           i_clock,
   input  wire logic           i_reset,
   fifo_write_arbiter_if.slave bus
);

   arb_state_t             r_state;
   arb_state_t             w_state_next;
   logic                   r_owner;        // 0: source 0, 1: source 1
   logic                   w_owner_next;
   logic                   r_rr_last;      // source served most recently
   logic                   w_rr_last_next;

   logic                   w_active;
   logic                   w_owner_valid;
   logic                   w_owner_last;
   logic [c_DATAWIDTH-1:0] w_owner_data;
   logic                   w_xfer;
   logic                   w_done;
   logic                   w_expired;
   logic                   w_abort;
   logic                   w_timer_clear;
   logic                   w_timer_enable;

   assign w_active      = (r_state == ST_GRANT);
   assign w_owner_valid = r_owner ? bus.req1_valid : bus.req0_valid;
   assign w_owner_last  = r_owner ? bus.req1_last  : bus.req0_last;
   assign w_owner_data  = r_owner ? bus.req1_data  : bus.req0_data;

   // A word moves only while owned, offered, and the FIFO has room
   assign w_xfer = w_active && w_owner_valid && !bus.fifo_full;
   assign w_done = w_xfer && w_owner_last;

   // Timeout reclaim loses to a last-word transfer in the same cycle
   assign w_abort = w_active && w_expired && !w_done;

   // Timer runs only while owned and the owner is silent; a full FIFO freezes it
   assign w_timer_clear  = !w_active || w_owner_valid;
   assign w_timer_enable = w_active && !w_owner_valid && !bus.fifo_full;

   fifo_write_arbiter_idle_timer #(
      .c_TIMEOUTW (c_TIMEOUTW)
   ) u_idle_timer (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_clear   (w_timer_clear),
      .i_enable  (w_timer_enable),
      .o_expired (w_expired)
   );

   // State, owner and round-robin pointer; pointer starts favouring source 0
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_owner   <= 1'b0;
         r_rr_last <= 1'b1;
      end else begin
         r_state   <= w_state_next;
         r_owner   <= w_owner_next;
         r_rr_last <= w_rr_last_next;
      end
   end

   // Next-state selection and handshake/FIFO outputs
   always_comb begin
      w_state_next     = r_state;
      w_owner_next     = r_owner;
      w_rr_last_next   = r_rr_last;
      bus.fifo_writeen = w_xfer;
      bus.fifo_data    = w_owner_data;
      bus.req0_ready   = w_xfer && !r_owner;
      bus.req1_ready   = w_xfer &&  r_owner;
      bus.grant        = w_active ? owner_to_grant(r_owner) : GNT_NONE;
      bus.abort        = w_abort;

      case (r_state)
         ST_IDLE: begin
            if ((bus.req0_valid || bus.req1_valid) && !bus.fifo_nearfull) begin
               w_state_next = ST_GRANT;
               if (bus.req0_valid && bus.req1_valid) begin
                  w_owner_next = ~r_rr_last;
               end else begin
                  w_owner_next = bus.req1_valid;
               end
            end
         end
         ST_GRANT: begin
            if (w_done || w_abort) begin
               w_state_next   = ST_IDLE;
               w_rr_last_next = r_owner;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_fifo_write_arbiter                                      |
// | Self-checking bench: FIFO writes are matched against a queue of      |
// | expected words; grant/abort/ready timing is checked per scenario.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_fifo_write_arbiter;
   import fifo_write_arbiter_pkg::*;

   localparam int c_DW = 8;
   localparam int c_TW = 4;

   logic clk = 1'b0;
   logic rst;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   fifo_write_arbiter_if #(.c_DATAWIDTH(c_DW)) bus ();

   fifo_write_arbiter #(
      .c_DATAWIDTH (c_DW),
      .c_TIMEOUTW  (c_TW)
   ) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   task automatic set_src(input int s, input logic v, input logic [7:0] d, input logic l);
      if (s == 0) begin
         bus.req0_valid = v; bus.req0_data = d; bus.req0_last = l;
      end else begin
         bus.req1_valid = v; bus.req1_data = d; bus.req1_last = l;
      end
   endtask

   function automatic logic src_ready(input int s);
      return (s == 0) ? bus.req0_ready : bus.req1_ready;
   endfunction

   // Offer n words base, base+1, ... holding each until accepted
   task automatic send_pkt(input int s, input int n, input logic [7:0] base, input logic with_last);
      for (int k = 0; k < n; k++) begin
         int wait_cyc;
         wait_cyc = 0;
         set_src(s, 1'b1, base + 8'(k), with_last && (k == n - 1));
         @(negedge clk);
         while (!src_ready(s) && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
         end
         n_checks++;
         if (src_ready(s) !== 1'b1)
            $display("FAIL handshake src%0d word%0d: ready=%b after %0d cycles, expected 1", s, k, src_ready(s), wait_cyc);
         else n_pass++;
         @(posedge clk); #1;
      end
      set_src(s, 1'b0, 8'h00, 1'b0);
   endtask

   // Scoreboard: every FIFO write pops and compares the next expected word
   task automatic monitor();
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         if (bus.fifo_writeen === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL fifo_write: got unexpected word %02h, expected no write", bus.fifo_data);
            end else begin
               exp = exp_q.pop_front();
               if (bus.fifo_data !== exp || bus.fifo_full !== 1'b0)
                  $display("FAIL fifo_write: got %02h (full=%b), expected %02h with full=0", bus.fifo_data, bus.fifo_full, exp);
               else n_pass++;
            end
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_src(0, 1'b0, 8'h00, 1'b0);
      set_src(1, 1'b0, 8'h00, 1'b0);
      bus.fifo_full = 1'b0;
      bus.fifo_nearfull = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_src(0, 1'b1, 8'h11, 1'b1);
      set_src(1, 1'b1, 8'h22, 1'b1);
      bus.fifo_full = 1'b0;
      bus.fifo_nearfull = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.grant !== GNT_NONE) $display("FAIL reset_grant: got %b expected %b", bus.grant, GNT_NONE); else n_pass++;
      n_checks++; if (bus.abort !== 1'b0) $display("FAIL reset_abort: got %b expected 0", bus.abort); else n_pass++;
      n_checks++; if (bus.fifo_writeen !== 1'b0) $display("FAIL reset_writeen: got %b expected 0", bus.fifo_writeen); else n_pass++;
      n_checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) $display("FAIL reset_ready: got %b expected 00", {bus.req1_ready, bus.req0_ready}); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.grant !== GNT_NONE) $display("FAIL reset_hold_grant: got %b expected %b", bus.grant, GNT_NONE); else n_pass++;
      set_src(0, 1'b0, 8'h00, 1'b0);
      set_src(1, 1'b0, 8'h00, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_single();
      @(posedge clk); #1;
      exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
      set_src(0, 1'b1, 8'hA1, 1'b0);
      @(negedge clk);
      n_checks++; if (bus.grant !== GNT_NONE) $display("FAIL single_latency_grant: got %b expected %b", bus.grant, GNT_NONE); else n_pass++;
      n_checks++; if (bus.req0_ready !== 1'b0) $display("FAIL single_idle_ready: got %b expected 0", bus.req0_ready); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.grant !== GNT_0) $display("FAIL single_grant: got %b expected %b", bus.grant, GNT_0); else n_pass++;
      @(posedge clk); #1 set_src(0, 1'b1, 8'hA2, 1'b0);
      @(posedge clk); #1 set_src(0, 1'b1, 8'hA3, 1'b1);
      @(posedge clk); #1 set_src(0, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      n_checks++; if (bus.grant !== GNT_NONE) $display("FAIL single_release: got %b expected %b", bus.grant, GNT_NONE); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL single_drain: got %0d words pending expected 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_contention();
      do_reset();
      exp_q.push_back(8'h10); exp_q.push_back(8'h11);
      exp_q.push_back(8'h20); exp_q.push_back(8'h21); exp_q.push_back(8'h22);
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h40); exp_q.push_back(8'h41);
      fork
         begin send_pkt(0, 2, 8'h10, 1'b1); send_pkt(0, 1, 8'h30, 1'b1); end
         begin send_pkt(1, 3, 8'h20, 1'b1); send_pkt(1, 2, 8'h40, 1'b1); end
      join
      @(negedge clk);
      n_checks++; if (exp_q.size() != 0) $display("FAIL contention_drain: got %0d words pending expected 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_nearfull();
      @(posedge clk); #1;
      bus.fifo_nearfull = 1'b1;
      exp_q.push_back(8'h50); exp_q.push_back(8'h51);
      set_src(1, 1'b1, 8'h50, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if (bus.grant !== GNT_NONE || bus.req1_ready !== 1'b0)
            $display("FAIL nearfull_gate: got grant=%b ready1=%b expected 00/0", bus.grant, bus.req1_ready);
         else n_pass++;
      end
      @(posedge clk); #1 bus.fifo_nearfull = 1'b0;
      fork
         send_pkt(1, 2, 8'h50, 1'b1);
         begin
            @(negedge clk);
            n_checks++; if (bus.grant !== GNT_NONE) $display("FAIL nearfull_release_latency: got %b expected %b", bus.grant, GNT_NONE); else n_pass++;
            @(negedge clk);
            n_checks++; if (bus.grant !== GNT_1) $display("FAIL nearfull_release_grant: got %b expected %b", bus.grant, GNT_1); else n_pass++;
         end
      join
      n_checks++; if (exp_q.size() != 0) $display("FAIL nearfull_drain: got %0d words pending expected 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_full_midpacket();
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) exp_q.push_back(8'h60 + 8'(i));
      fork
         send_pkt(0, 5, 8'h60, 1'b1);
         begin
            int cyc;
            cyc = 0;
            @(negedge clk);
            while (!(bus.fifo_writeen === 1'b1 && bus.fifo_data === 8'h61) && cyc < 50) begin
               @(negedge clk);
               cyc++;
            end
            n_checks++; if (cyc >= 50) $display("FAIL full_trigger: got no write of word 61 in %0d cycles, expected one", cyc); else n_pass++;
            @(posedge clk); #1;
            bus.fifo_full = 1'b1;
            bus.fifo_nearfull = 1'b1;
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               n_checks++; if (bus.fifo_writeen !== 1'b0 || bus.req0_ready !== 1'b0 || bus.abort !== 1'b0)
                  $display("FAIL full_stall: got writeen=%b ready0=%b abort=%b expected 0/0/0", bus.fifo_writeen, bus.req0_ready, bus.abort);
               else n_pass++;
            end
            @(posedge clk); #1 bus.fifo_full = 1'b0;
         end
      join
      bus.fifo_nearfull = 1'b0;
      @(negedge clk);
      n_checks++; if (exp_q.size() != 0) $display("FAIL full_drain: got %0d words pending expected 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_timeout();
      do_reset();
      exp_q.push_back(8'h70); exp_q.push_back(8'h71); exp_q.push_back(8'h80);
      fork
         begin
            int early;
            early = 0;
            send_pkt(0, 2, 8'h70, 1'b0);
            for (int i = 0; i < 15; i++) begin
               @(negedge clk);
               if (bus.abort !== 1'b0) early++;
            end
            n_checks++; if (early != 0) $display("FAIL timeout_early: got %0d abort cycles expected 0", early); else n_pass++;
            @(negedge clk);
            n_checks++; if (bus.abort !== 1'b1 || bus.grant !== GNT_0 || bus.req1_ready !== 1'b0)
               $display("FAIL timeout_abort: got abort=%b grant=%b ready1=%b expected 1/01/0", bus.abort, bus.grant, bus.req1_ready);
            else n_pass++;
            @(negedge clk);
            n_checks++; if (bus.abort !== 1'b0 || bus.grant !== GNT_NONE)
               $display("FAIL timeout_release: got abort=%b grant=%b expected 0/00", bus.abort, bus.grant);
            else n_pass++;
            @(negedge clk);
            n_checks++; if (bus.grant !== GNT_1) $display("FAIL timeout_other_granted: got %b expected %b", bus.grant, GNT_1); else n_pass++;
         end
         send_pkt(1, 1, 8'h80, 1'b1);
      join
      n_checks++; if (exp_q.size() != 0) $display("FAIL timeout_drain: got %0d words pending expected 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_async_reset();
      @(posedge clk); #1;
      exp_q.push_back(8'h8F);
      send_pkt(0, 1, 8'h8F, 1'b1);
      exp_q.push_back(8'h90); exp_q.push_back(8'h91);
      set_src(0, 1'b1, 8'h90, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1 set_src(0, 1'b1, 8'h91, 1'b0);
      @(posedge clk); #1 set_src(0, 1'b1, 8'h92, 1'b0);
      n_checks++; if (bus.fifo_writeen !== 1'b1) $display("FAIL areset_pre_write: got %b expected 1", bus.fifo_writeen); else n_pass++;
      #2 rst = 1'b1;
      set_src(1, 1'b1, 8'hB0, 1'b1);
      #1;
      n_checks++; if (bus.grant !== GNT_NONE || bus.fifo_writeen !== 1'b0 || bus.req0_ready !== 1'b0)
         $display("FAIL areset_immediate: got grant=%b writeen=%b ready0=%b expected 00/0/0", bus.grant, bus.fifo_writeen, bus.req0_ready);
      else n_pass++;
      @(posedge clk); #1;
      @(posedge clk); #1;
      set_src(0, 1'b1, 8'hA0, 1'b1);
      rst = 1'b0;
      exp_q.push_back(8'hA0); exp_q.push_back(8'hB0);
      fork
         send_pkt(0, 1, 8'hA0, 1'b1);
         send_pkt(1, 1, 8'hB0, 1'b1);
         begin
            @(negedge clk);
            n_checks++; if (bus.grant !== GNT_NONE) $display("FAIL areset_latency: got %b expected %b", bus.grant, GNT_NONE); else n_pass++;
            @(negedge clk);
            n_checks++; if (bus.grant !== GNT_0) $display("FAIL areset_favours_src0: got %b expected %b", bus.grant, GNT_0); else n_pass++;
         end
      join
      n_checks++; if (exp_q.size() != 0) $display("FAIL areset_drain: got %0d words pending expected 0", exp_q.size()); else n_pass++;
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_single();
      test_contention();
      test_nearfull();
      test_full_midpacket();
      test_timeout();
      test_async_reset();
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000 time units, expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
